read_mem_controller: RTL

- Read-side counterpart of the input-memory write controller in the image accelerator.
- Accepts a read request (address) from the compute side and drives a single-cycle read strobe and address into the input memory.
- Waits the memory's fixed read latency, captures the returned DATA_SIZE-bit word, and presents it downstream with a valid/ready handshake.
- One outstanding request at a time; the response is held stable under back-pressure.

---
 rtl/read_mem_pkg.sv | 15 +
 rtl/read_mem_controller_resp_buffer.sv | 55 +++++
 rtl/read_mem_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/read_mem_pkg.sv
// Shared types and default widths for the input-memory read/write controllers.
package read_mem_pkg;

  localparam int ADD_SIZE_DEF  = 12;
  localparam int DATA_SIZE_DEF = 108;
  localparam int LAT_CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/read_mem_controller_resp_buffer.sv
// read_resp_buffer: holds the captured read word and its valid flag until the consumer takes it.
// With READ_RANGE_CHECK_EN defined it also carries the out-of-range error flag.
module read_resp_buffer
  import read_mem_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] load_data,
`ifdef READ_RANGE_CHECK_EN
  input  logic                 load_err,
  output logic                 out_err,
`endif
  input  logic                 data_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 out_valid
);

  logic [DATA_SIZE-1:0] data_p0;
  logic                 vld_p0;
`ifdef READ_RANGE_CHECK_EN
  logic                 err_p0;
`endif

  // Capture stage: data is kept after the handshake, only valid/err clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
`ifdef READ_RANGE_CHECK_EN
      err_p0  <= 1'b0;
`endif
    end else if (load) begin
      data_p0 <= load_data;
      vld_p0  <= 1'b1;
`ifdef READ_RANGE_CHECK_EN
      err_p0  <= load_err;
`endif
    end else if (vld_p0 && data_ready) begin
      vld_p0  <= 1'b0;
`ifdef READ_RANGE_CHECK_EN
      err_p0  <= 1'b0;
`endif
    end
  end

  assign data_out  = data_p0;
  assign out_valid = vld_p0;
`ifdef READ_RANGE_CHECK_EN
  assign out_err   = err_p0;
`endif

endmodule

// File: rtl/read_mem_controller.sv
// Read controller for the input memory: one request in flight, fixed-latency read, held response.
// Optional READ_RANGE_CHECK_EN adds out_err and answers out-of-range addresses without a memory access.
module read_mem_controller
  import read_mem_pkg::*;
#(
  parameter int ADD_SIZE     = ADD_SIZE_DEF,
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int READ_LATENCY = 1,
  parameter int MEM_DEPTH    = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_en,
  input  logic                 in_valid,
  input  logic [ADD_SIZE-1:0]  address_in,
  output logic                 out_ready,
  output logic                 read_en_out,
  output logic [ADD_SIZE-1:0]  address_out,
  input  logic [DATA_SIZE-1:0] mem_data_in,
  output logic [DATA_SIZE-1:0] dataOut,
  output logic                 out_valid,
`ifdef READ_RANGE_CHECK_EN
  output logic                 out_err,
`endif
  input  logic                 data_ready
);

  if (READ_LATENCY < 1 || READ_LATENCY > 7 || MEM_DEPTH < 1) begin : g_bad_param
    $error("read_mem_controller: READ_LATENCY must be 1..7 and MEM_DEPTH positive");
  end

  state_t               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADD_SIZE-1:0]  addr_q, addr_d;
  logic                 accept;
  logic                 load;
  logic [DATA_SIZE-1:0] load_data;
`ifdef READ_RANGE_CHECK_EN
  logic                 load_err;
  logic                 addr_bad;

  assign addr_bad = (32'(address_in) >= 32'(MEM_DEPTH));
`endif

  assign out_ready   = rst && (state_q == IDLE);
  assign read_en_out = (state_q == ISSUE);
  assign address_out = addr_q;
  assign accept      = in_valid && read_en && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    load      = 1'b0;
    load_data = mem_data_in;
`ifdef READ_RANGE_CHECK_EN
    load_err  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = address_in;
`ifdef READ_RANGE_CHECK_EN
          if (addr_bad) begin
            load      = 1'b1;
            load_data = '0;
            load_err  = 1'b1;
            state_d   = RESP;
          end else
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT_CNT_W'(READ_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        // The edge where the counter would hit zero is the one where memory data is valid.
        if (cnt_q <= LAT_CNT_W'(1)) begin
          cnt_d   = '0;
          load    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP: begin
        if (out_valid && data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  read_resp_buffer #(
    .DATA_SIZE (DATA_SIZE)
  ) u_resp_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
`ifdef READ_RANGE_CHECK_EN
    .load_err   (load_err),
    .out_err    (out_err),
`endif
    .data_ready (data_ready),
    .data_out   (dataOut),
    .out_valid  (out_valid)
  );

endmodule
